// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: Avalon-MM slave driving the SD card clock pin (pulse bursts, free-run, manual level).
// Latency: register writes act on the next clk edge; readdata is combinational (zero wait states).
// Backpressure: none, every access completes in one cycle. Optional irq port under SD_CLK_CTRL_IRQ_EN.
module sd_clk_ctrl #(
   parameter int DIV_W       = 16,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 63
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
`ifdef SD_CLK_CTRL_IRQ_EN
   output logic        irq,
`endif
   output logic        out_port
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;

   localparam logic [DIV_W-1:0] DIV_RST = DEFAULT_DIV[DIV_W-1:0];
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_half_cnt;
   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_remaining;
   logic             r_manual;
   logic             r_freerun;
   logic             r_done;
   logic             r_out;

   logic             w_wr;
   logic             w_wr_ctrl;
   logic             w_wr_div;
   logic             w_wr_pul;
   logic             w_wr_stat;
   logic [CNT_W-1:0] w_n;
   logic             w_n_nz;
   logic             w_phase_end;
   logic             w_burst;
   logic             w_load_burst;
   logic             w_dec;
   logic             w_burst_done;
   logic             w_abort;
   logic             w_manual_nxt;
   logic             w_out_nxt;
   logic             w_unused;

   assign w_wr        = chipselect & ~write_n;
   assign w_wr_ctrl   = w_wr && (address == 2'd0);
   assign w_wr_div    = w_wr && (address == 2'd1);
   assign w_wr_pul    = w_wr && (address == 2'd2);
   assign w_wr_stat   = w_wr && (address == 2'd3);
   assign w_n         = writedata[CNT_W-1:0];
   assign w_n_nz      = (w_n != '0);
   assign w_phase_end = (r_half_cnt == '0);
   // A non-zero remaining count means the running clock is a burst, not free-run.
   assign w_burst     = (r_remaining != '0);
   assign w_unused    = ^writedata;
   assign out_port    = r_out;

   // FSM state register; the half-period counter reloads from DIV at every phase start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_half_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == S_IDLE)
            r_half_cnt <= '0;
         else if (w_state_nxt != r_state)
            r_half_cnt <= r_div;
         else
            r_half_cnt <= r_half_cnt - DIV_ONE;
      end
   end

   // FSM next state: bursts beat free-run, stops happen only at the end of HIGH, N=0 aborts.
   always_comb begin
      w_state_nxt  = r_state;
      w_load_burst = 1'b0;
      w_dec        = 1'b0;
      w_burst_done = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_wr_pul && w_n_nz) begin
               w_state_nxt  = S_LOW;
               w_load_burst = 1'b1;
            end else if (r_freerun) begin
               w_state_nxt = S_LOW;
            end
         end
         S_LOW: begin
            if (w_phase_end)
               w_state_nxt = S_HIGH;
         end
         S_HIGH: begin
            if (w_phase_end) begin
               if (w_burst) begin
                  w_dec = 1'b1;
                  if (r_remaining == CNT_ONE) begin
                     w_state_nxt  = S_IDLE;
                     w_burst_done = 1'b1;
                  end else begin
                     w_state_nxt = S_LOW;
                  end
               end else if (r_freerun) begin
                  w_state_nxt = S_LOW;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if ((r_state != S_IDLE) && w_wr_pul && !w_n_nz) begin
         w_state_nxt  = S_IDLE;
         w_abort      = 1'b1;
         w_dec        = 1'b0;
         w_burst_done = 1'b0;
      end
   end

   // FSM output decode: pin level for the coming cycle, manual level tracks a same-cycle CTRL write.
   always_comb begin
      w_manual_nxt = w_wr_ctrl ? writedata[0] : r_manual;
      case (w_state_nxt)
         S_LOW:   w_out_nxt = 1'b0;
         S_HIGH:  w_out_nxt = 1'b1;
         default: w_out_nxt = w_manual_nxt;
      endcase
   end

   // Registered pin drive so the SD clock never sees combinational glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_out <= 1'b0;
      else
         r_out <= w_out_nxt;
   end

   // CTRL and DIV registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_manual  <= 1'b0;
         r_freerun <= 1'b0;
         r_div     <= DIV_RST;
      end else begin
         r_manual <= w_manual_nxt;
         if (w_wr_ctrl)
            r_freerun <= writedata[1];
         if (w_wr_div)
            r_div <= writedata[DIV_W-1:0];
      end
   end

   // Remaining pulse count: load on burst start, count down per completed pulse, zero on abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_remaining <= '0;
      else if (w_abort)
         r_remaining <= '0;
      else if (w_load_burst)
         r_remaining <= w_n;
      else if (w_dec)
         r_remaining <= r_remaining - CNT_ONE;
   end

   // Sticky done flag; completion in the same cycle as a STATUS write keeps it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_done <= 1'b0;
      else if (w_burst_done)
         r_done <= 1'b1;
      else if (w_wr_stat)
         r_done <= 1'b0;
   end

`ifdef SD_CLK_CTRL_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   // Interrupt enable bit and registered interrupt line (done qualified by enable).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ctrl)
            r_irq_en <= writedata[2];
         r_irq <= r_done & r_irq_en;
      end
   end

   assign irq = r_irq;
`endif

   // Zero-wait-state read mux.
   always_comb begin
      readdata = '0;
      case (address)
`ifdef SD_CLK_CTRL_IRQ_EN
         2'd0: readdata = {29'b0, r_irq_en, r_freerun, r_manual};
`else
         2'd0: readdata = {30'b0, r_freerun, r_manual};
`endif
         2'd1: readdata = 32'(r_div);
         2'd2: readdata = 32'(r_remaining);
         default: readdata = {29'b0, r_done, r_out, (r_state != S_IDLE)};
      endcase
   end

endmodule
